// File: rtl/instr_register_param_pkg.sv
// instr_register_pkg: shared types and constants for the parametrised
// instruction register.
//   opcode_t     - stored operation encoding (4 bits, 8 defined values)
//   DEF_OP_W     - default signed operand width
//   DEF_DEPTH    - default number of entries
//   ref_result() - reference result at the default widths, for the checker
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  localparam int DEF_OP_W  = 32;
  localparam int DEF_DEPTH = 32;

  // Operands arrive already sign-extended to 64 bits. A zero divisor
  // yields 0; the div0 flag is the caller's concern.
  function automatic longint ref_result(opcode_t op, longint a, longint b);
    case (op)
      PASSA:   return a;
      PASSB:   return b;
      ADD:     return a + b;
      SUB:     return a - b;
      MULT:    return a * b;
      DIV:     return (b == 0) ? 64'sd0 : a / b;
      MOD:     return (b == 0) ? 64'sd0 : a % b;
      default: return 64'sd0;
    endcase
  endfunction

endpackage

// File: rtl/instr_register_param_if.sv
// instr_register_param_if: write/read bus of the instruction register.
//   master - stimulus side: drives write and read requests, sees read data
//   slave  - register side: receives requests, drives read data and wr_count
import instr_register_pkg::*;

interface instr_register_param_if #(
  parameter int OP_W  = DEF_OP_W,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int RES_W = 2 * OP_W;

  logic                    load_en;
  logic [PTR_W-1:0]        write_pointer;
  opcode_t                 opcode;
  logic signed [OP_W-1:0]  operand_a;
  logic signed [OP_W-1:0]  operand_b;
  logic                    read_en;
  logic [PTR_W-1:0]        read_pointer;

  logic                    rd_valid;
  logic                    rd_hit;
  opcode_t                 rd_opcode;
  logic signed [OP_W-1:0]  rd_op_a;
  logic signed [OP_W-1:0]  rd_op_b;
  logic signed [RES_W-1:0] rd_result;
  logic                    rd_div0;
  logic [PTR_W:0]          wr_count;

  modport master (
    output load_en, write_pointer, opcode, operand_a, operand_b,
           read_en, read_pointer,
    input  rd_valid, rd_hit, rd_opcode, rd_op_a, rd_op_b, rd_result,
           rd_div0, wr_count
  );

  modport slave (
    input  load_en, write_pointer, opcode, operand_a, operand_b,
           read_en, read_pointer,
    output rd_valid, rd_hit, rd_opcode, rd_op_a, rd_op_b, rd_result,
           rd_div0, wr_count
  );
endinterface

// File: rtl/instr_register_param_alu.sv
// instr_alu: combinational result generator on the register write path.
//   opcode     - operation
//   a, b       - signed OP_W operands
//   result     - signed RES_W result (operands sign-extended first)
//   div0       - DIV/MOD with b == 0; result forced to 0 in that case
import instr_register_pkg::*;

module instr_alu #(
  parameter int OP_W  = DEF_OP_W,
  parameter int RES_W = 2 * OP_W
) (
  input  opcode_t                 opcode,
  input  logic signed [OP_W-1:0]  a,
  input  logic signed [OP_W-1:0]  b,
  output logic signed [RES_W-1:0] result,
  output logic                    div0
);
  logic signed [RES_W-1:0] ax, bx;
  logic                    b_zero;

  // Widening before the arithmetic keeps MULT exact and lets
  // most-negative / -1 come out as +2^(OP_W-1) instead of overflowing.
  assign ax     = {{(RES_W-OP_W){a[OP_W-1]}}, a};
  assign bx     = {{(RES_W-OP_W){b[OP_W-1]}}, b};
  assign b_zero = (b == '0);

  always_comb begin
    result = '0;
    div0   = 1'b0;
    case (opcode)
      ZERO:  result = '0;
      PASSA: result = ax;
      PASSB: result = bx;
      ADD:   result = ax + bx;
      SUB:   result = ax - bx;
      MULT:  result = ax * bx;
      DIV: begin
        if (b_zero) div0   = 1'b1;
        else        result = ax / bx;   // SV signed '/' truncates toward zero
      end
      MOD: begin
        if (b_zero) div0   = 1'b1;
        else        result = ax % bx;   // sign follows the dividend
      end
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/instr_register_param.sv
// instr_register_param: DEPTH-entry opcode/operand store with the ALU
// result captured at write time.
//   clk      - clock, rising edge
//   reset_n  - asynchronous active-low reset, clears every entry
//   bus      - instr_register_param_if.slave: write port, registered read
//              port (1-cycle latency, rd_valid pulse), wr_count
import instr_register_pkg::*;

module instr_register_param #(
  parameter int OP_W  = DEF_OP_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int RES_W = 2 * OP_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  instr_register_param_if.slave  bus
);
  typedef struct packed {
    opcode_t                 opcode;
    logic signed [OP_W-1:0]  op_a;
    logic signed [OP_W-1:0]  op_b;
    logic signed [RES_W-1:0] result;
    logic                    div0;
  } entry_t;

  entry_t               mem [DEPTH];
  logic [DEPTH-1:0]     written;
  logic [PTR_W:0]       wr_count;
  entry_t               rd_q;
  logic                 rd_hit_q;
  logic                 rd_valid_q;

  logic signed [RES_W-1:0] alu_result;
  logic                    alu_div0;
  logic                    wr_ok, rd_ok;
  entry_t                  wr_entry;

  instr_alu #(.OP_W(OP_W), .RES_W(RES_W)) u_alu (
    .opcode (bus.opcode),
    .a      (bus.operand_a),
    .b      (bus.operand_b),
    .result (alu_result),
    .div0   (alu_div0)
  );

  // Pointers can exceed DEPTH-1 only when DEPTH is not a power of two.
  assign wr_ok = ({1'b0, bus.write_pointer} < (PTR_W+1)'(DEPTH));
  assign rd_ok = ({1'b0, bus.read_pointer}  < (PTR_W+1)'(DEPTH));

  assign wr_entry = '{opcode: bus.opcode, op_a: bus.operand_a,
                      op_b: bus.operand_b, result: alu_result,
                      div0: alu_div0};

  // Read and write share one edge; the read samples the pre-edge array,
  // which gives read-before-write on a same-address collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      written    <= '0;
      wr_count   <= '0;
      rd_q       <= '0;
      rd_hit_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      if (bus.load_en && wr_ok) begin
        mem[bus.write_pointer]     <= wr_entry;
        written[bus.write_pointer] <= 1'b1;
        // Only first writes count, so wr_count tops out at DEPTH.
        if (!written[bus.write_pointer])
          wr_count <= wr_count + (PTR_W+1)'(1);
      end

      rd_valid_q <= bus.read_en;
      if (bus.read_en) begin
        if (rd_ok) begin
          rd_q     <= mem[bus.read_pointer];
          rd_hit_q <= written[bus.read_pointer];
        end else begin
          rd_q     <= '0;
          rd_hit_q <= 1'b0;
        end
      end
    end
  end

  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_hit    = rd_hit_q;
  assign bus.rd_opcode = rd_q.opcode;
  assign bus.rd_op_a   = rd_q.op_a;
  assign bus.rd_op_b   = rd_q.op_b;
  assign bus.rd_result = rd_q.result;
  assign bus.rd_div0   = rd_q.div0;
  assign bus.wr_count  = wr_count;
endmodule

// File: doc/instr_register_param.md
Name: instr_register_param

Overview:
- Parametrised successor to the fixed 32-entry instruction register.
- Stores opcode/operand pairs at a write pointer and computes the ALU result at write time, so no later compute stage is needed.
- Provides a registered, validated read port with a per-entry "written" flag and a live-entry counter.
- Sits between the stimulus interface and the checker; the checker compares read-back results against its own model.

Parameters:
- OP_W, 32, signed operand width in bits (min 2).
- DEPTH, 32, number of register entries (min 2; need not be a power of two).
- PTR_W, $clog2(DEPTH), pointer width; derived, do not override.
- RES_W, 2*OP_W, result width, sized to hold the full MULT product.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load_en  in  1  write strobe; stores an entry this cycle.
- write_pointer  in  PTR_W  write address.
- opcode  in  opcode_t (4)  operation to store.
- operand_a  in  OP_W  signed operand A.
- operand_b  in  OP_W  signed operand B.
- read_en  in  1  read request.
- read_pointer  in  PTR_W  read address.
- rd_valid  out  1  one-cycle pulse; read data below is valid.
- rd_hit  out  1  addressed entry had been written since reset.
- rd_opcode  out  opcode_t  stored opcode.
- rd_op_a  out  OP_W  stored operand A.
- rd_op_b  out  OP_W  stored operand B.
- rd_result  out  RES_W  stored result.
- rd_div0  out  1  stored entry was DIV/MOD with operand_b==0.
- wr_count  out  PTR_W+1  number of distinct entries written since reset.

Behaviour:
- Reset (async assert, sync release):
  - All entries cleared: opcode=ZERO, operands, result and div0 = 0, written flag = 0.
  - All outputs 0; wr_count 0.
  - Reset asserted mid-operation aborts any pending read; rd_valid is forced 0 immediately.
- Write:
  - When load_en=1 and write_pointer<DEPTH, the entry is updated at the clock edge with {opcode, operand_a, operand_b, result, div0}.
  - The entry's written flag is set.
  - wr_count increments only if the flag was previously 0.
  - Rewriting an already-written entry overwrites all fields and leaves wr_count unchanged.
- Result (combinational, computed from inputs at write time; operands sign-extended to RES_W first):
  - ZERO -> 0.
  - PASSA -> a.
  - PASSB -> b.
  - ADD -> a+b.
  - SUB -> a-b.
  - MULT -> a*b (full signed product).
  - DIV -> a/b, truncated toward zero.
  - MOD -> a%b, sign follows a.
  - DIV/MOD with b==0: result 0 and div0=1. div0 is 0 for all other cases.
  - Most-negative/-1 DIV: result is +2^(OP_W-1) in RES_W (no overflow, because of the wider result).
- Read:
  - When read_en=1, outputs register the entry at read_pointer on the next edge, and rd_valid pulses 1 for one cycle. Latency is 1 cycle.
  - When read_en=0, rd_valid=0 and the data outputs hold their last value.
  - Back-to-back reads are allowed every cycle.
- Same-address read and write in the same cycle: read-before-write. The read returns the old contents and the old rd_hit; the new data is visible to the next read.
- Out-of-range pointer (>=DEPTH, non-power-of-two DEPTH only):
  - Write is ignored.
  - Read gives rd_valid=1, rd_hit=0, all data 0.
- wr_count saturates at DEPTH by construction; no wrap.
- Every opcode_t value is a legal stored value; there are no illegal encodings.

Decomposition:
- Package instr_register_pkg holds:
  - opcode_t: enum logic[3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD}.
  - default OP_W/DEPTH constants.
  - a shared reference result function used by the checker.
- Sub-module instr_alu (params OP_W, RES_W): purely combinational; inputs opcode, a, b; outputs result, div0. The register instantiates it on the write path.

Test Plan:
- Reset then read addr 0 -> rd_valid=1 one cycle later, rd_hit=0, rd_opcode=ZERO, rd_result=0, wr_count=0.
- Write addr 3: ADD a=-7, b=5, then read 3 -> rd_result=-2 (sign-extended), rd_hit=1, wr_count=1. Rewrite addr 3 with MULT a=-40000, b=70000, then read -> rd_result=-2800000000 (64-bit), wr_count still 1.
- DIV a=-9, b=2 -> rd_result=-4. MOD a=-9, b=2 -> rd_result=-1. DIV a=5, b=0 -> rd_result=0, rd_div0=1.
- Same cycle: write addr 1 (PASSA a=11) and read addr 1, previously holding SUB 4-1=3 -> read shows result 3. Next read -> 11.
- DEPTH=20: write addr 25 -> wr_count unchanged. Read addr 25 -> rd_valid=1, rd_hit=0, data 0. Write all 20 addresses -> wr_count=20.
- Assert reset_n low between read_en and the following edge -> rd_valid stays 0, all entries cleared, wr_count=0 on release.
